// File: rtl/seq_detect_param_if.sv
// Serial stream interface for the parametrised pattern detector:
// qualified input bits in, match pulse and running match count out.
interface seq_detect_param_if #(
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din_valid,
        output din,
        input  match,
        input  match_cnt
    );

    modport slave (
        input  din_valid,
        input  din,
        output match,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-pattern detector with overlap/non-overlap
// modes, valid-qualified input and a saturating match counter.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               overlap,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               clr_cnt,
    output logic               busy,
    seq_detect_param_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HUNT
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state, state_next;
    logic [MAX_LEN-1:0] window, window_next;
    logic [MAX_LEN-1:0] lat_pattern, lat_pattern_next;
    logic [MAX_LEN-1:0] len_mask, shifted;
    logic [LEN_W-1:0]   fill_cnt, fill_next, fill_inc;
    logic [LEN_W-1:0]   lat_len, lat_len_next, len_clamped;
    logic               lat_overlap, lat_overlap_next;
    logic               match_r, match_next;
    logic [CNT_W-1:0]   cnt_r, cnt_next;
    logic               accept, hit;

    // Zero or oversized lengths fall back to the full window width.
    always_comb begin
        len_clamped = pat_len;
        if (pat_len == '0 || pat_len > MAX_LEN_L) begin
            len_clamped = MAX_LEN_L;
        end
    end

    // Compare only the low L bits of the post-shift window; upper bits are don't-care.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(lat_len));
        end
        shifted  = {window[MAX_LEN-2:0], bus.din};
        accept   = (state != IDLE) && enable && bus.din_valid;
        fill_inc = (fill_cnt == lat_len) ? fill_cnt : fill_cnt + LEN_W'(1);
        hit      = accept && (fill_inc == lat_len)
                   && (((shifted ^ lat_pattern) & len_mask) == '0);
    end

    always_comb begin
        state_next       = state;
        window_next      = window;
        fill_next        = fill_cnt;
        lat_pattern_next = lat_pattern;
        lat_len_next     = lat_len;
        lat_overlap_next = lat_overlap;
        match_next       = hit;
        cnt_next         = cnt_r;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next       = FILL;
                    lat_pattern_next = pattern;
                    lat_len_next     = len_clamped;
                    lat_overlap_next = overlap;
                    window_next      = '0;
                    fill_next        = '0;
                end
            end
            FILL, HUNT: begin
                if (!enable) begin
                    state_next  = IDLE;
                    window_next = '0;
                    fill_next   = '0;
                end else if (accept) begin
                    window_next = shifted;
                    fill_next   = fill_inc;
                    // Non-overlap mode demands L fresh bits after every match.
                    if (hit && !lat_overlap) begin
                        state_next = FILL;
                        fill_next  = '0;
                    end else if (fill_inc == lat_len) begin
                        state_next = HUNT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A match coinciding with a clear leaves the counter at one.
        if (clr_cnt) begin
            cnt_next = hit ? CNT_W'(1) : '0;
        end else if (hit && cnt_r != CNT_MAX) begin
            cnt_next = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            window      <= '0;
            fill_cnt    <= '0;
            lat_pattern <= '0;
            lat_len     <= '0;
            lat_overlap <= 1'b0;
            match_r     <= 1'b0;
            cnt_r       <= '0;
        end else begin
            state       <= state_next;
            window      <= window_next;
            fill_cnt    <= fill_next;
            lat_pattern <= lat_pattern_next;
            lat_len     <= lat_len_next;
            lat_overlap <= lat_overlap_next;
            match_r     <= match_next;
            cnt_r       <= cnt_next;
        end
    end

    assign bus.match     = match_r;
    assign bus.match_cnt = cnt_r;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: stimulus pushes expected match
// cycle/count, an independent monitor pops and compares on every match pulse.
module tb_seq_detect_param;

    localparam int MAX_LEN   = 8;
    localparam int LEN_W     = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_W_SAT = 2;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               enable  = 1'b0;
    logic               overlap = 1'b0;
    logic               clr_cnt = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               busy;
    logic               busy_sat;

    int   cyc       = 0;
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    exp_t sb_q[$];

    seq_detect_param_if #(.CNT_W(CNT_W))     bus ();
    seq_detect_param_if #(.CNT_W(CNT_W_SAT)) bus_sat ();

    assign bus_sat.din_valid = bus.din_valid;
    assign bus_sat.din       = bus.din;

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .overlap (overlap),
        .pattern (pattern),
        .pat_len (pat_len),
        .clr_cnt (clr_cnt),
        .busy    (busy),
        .bus     (bus)
    );

    // Narrow-counter twin sees identical stimulus to exercise saturation.
    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W_SAT)) u_dut_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .overlap (overlap),
        .pattern (pattern),
        .pat_len (pat_len),
        .clr_cnt (clr_cnt),
        .busy    (busy_sat),
        .bus     (bus_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic clr,
                                 input logic exp_match, input int exp_cnt);
        exp_t e;
        @(negedge clk);
        bus.din_valid = v;
        bus.din       = d;
        clr_cnt       = clr;
        if (exp_match) begin
            e.cyc = cyc + 1;
            e.cnt = exp_cnt;
            sb_q.push_back(e);
        end
    endtask

    task automatic sendBit(input logic d, input logic exp_match, input int exp_cnt);
        applyStimulus(1'b1, d, 1'b0, exp_match, exp_cnt);
    endtask

    task automatic gap(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic startDetector(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                                 input logic ovl);
        @(negedge clk);
        enable        = 1'b0;
        bus.din_valid = 1'b0;
        clr_cnt       = 1'b0;
        pattern       = pat;
        pat_len       = len;
        overlap       = ovl;
        @(negedge clk);
        enable = 1'b1;
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (bus.match === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_match", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("match_cycle", cyc, e.cyc);
                checkOutput("match_cnt_at_pulse", int'(bus.match_cnt), e.cnt);
            end
        end
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_match", int'(bus.match), 0);
        checkOutput("reset_cnt", int'(bus.match_cnt), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        $display("[TB] overlap mode 0101");
        startDetector(8'h05, 4'd4, 1'b1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 1);
        sendBit(0, 0, 0); sendBit(1, 1, 2);
        gap(2);
        checkOutput("ovl_cnt", int'(bus.match_cnt), 2);
        checkOutput("ovl_busy", int'(busy), 1);

        $display("[TB] non-overlap mode 0101");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
        startDetector(8'h05, 4'd4, 1'b0);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 2);
        gap(2);
        checkOutput("novl_cnt", int'(bus.match_cnt), 2);

        $display("[TB] valid gaps 1101");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
        startDetector(8'h0D, 4'd4, 1'b1);
        sendBit(1, 0, 0); gap(3);
        sendBit(1, 0, 0); gap(3);
        sendBit(0, 0, 0); gap(3);
        sendBit(1, 1, 1);
        gap(2);
        checkOutput("gap_cnt", int'(bus.match_cnt), 1);

        $display("[TB] length one");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
        startDetector(8'h01, 4'd1, 1'b1);
        sendBit(1, 1, 1); sendBit(1, 1, 2); sendBit(0, 0, 0); sendBit(1, 1, 3);
        gap(2);
        checkOutput("len1_cnt", int'(bus.match_cnt), 3);

        $display("[TB] length zero clamps to max");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
        startDetector(8'hA5, 4'd0, 1'b1);
        sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 1);
        gap(2);
        checkOutput("len0_cnt", int'(bus.match_cnt), 1);

        $display("[TB] counter saturation and clear");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
        startDetector(8'h01, 4'd1, 1'b1);
        for (int i = 1; i <= 5; i++) sendBit(1, 1, i);
        gap(2);
        checkOutput("sat_wide_cnt", int'(bus.match_cnt), 5);
        checkOutput("sat_narrow_cnt", int'(bus_sat.match_cnt), 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
        gap(2);
        checkOutput("clr_hit_cnt", int'(bus.match_cnt), 1);
        checkOutput("clr_hit_narrow_cnt", int'(bus_sat.match_cnt), 1);

        $display("[TB] enable drop discards partial window");
        startDetector(8'h05, 4'd4, 1'b1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0);
        @(negedge clk);
        enable        = 1'b0;
        bus.din_valid = 1'b0;
        @(negedge clk);
        checkOutput("drop_busy", int'(busy), 0);
        checkOutput("drop_cnt_kept", int'(bus.match_cnt), 1);
        startDetector(8'h05, 4'd4, 1'b1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 2);
        gap(2);
        checkOutput("drop_cnt", int'(bus.match_cnt), 2);

        $display("[TB] reset mid-stream");
        startDetector(8'h05, 4'd4, 1'b1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0);
        @(negedge clk);
        bus.din_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        checkOutput("rst_match", int'(bus.match), 0);
        checkOutput("rst_cnt", int'(bus.match_cnt), 0);
        checkOutput("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        startDetector(8'h05, 4'd4, 1'b1);
        sendBit(0, 0, 0); sendBit(1, 0, 0); sendBit(0, 0, 0); sendBit(1, 1, 1);
        gap(3);
        checkOutput("post_rst_cnt", int'(bus.match_cnt), 1);

        checkOutput("pending_expect", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
